// File: rtl/pipe_pkg.sv
// Shared types and constants for valid/ready pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: one cycle from inc to q, holds at all-ones, clr wins.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: 1-cycle latency, FIFO order; SKID=1 gives a registered up_ready
// via a second entry, SKID=0 passes dn_ready combinationally. Flush drops held and incoming beats.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                SKID   = 1,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR),
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              rdy_q;
  logic              main_valid;
  logic              up_xfer;
  logic              dn_xfer;
  logic              load_main_up;
  logic              load_main_skid;
  logic              load_skid;

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  // rdy_q is precomputed from the next state so up_ready leaves straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != ST_SKIDDED);
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_up) begin
      main_q <= up_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= up_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (up_xfer) begin
          state_nxt    = ST_FULL;
          load_main_up = 1'b1;
        end
      end
      ST_FULL: begin
        if (up_xfer && dn_xfer) begin
          load_main_up = 1'b1;
        end else if (up_xfer) begin
          state_nxt = ST_SKIDDED;
          load_skid = 1'b1;
        end else if (dn_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKIDDED: begin
        if (dn_xfer) begin
          state_nxt      = ST_FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_up   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_comb begin
    main_valid = (state != ST_EMPTY);
    dn_valid   = main_valid;
    dn_data    = main_valid ? main_q : BUBBLE;
    occupancy  = (state == ST_SKIDDED) ? 2'd2 : (main_valid ? 2'd1 : 2'd0);
    up_ready   = (SKID != 0) ? rdy_q : (!main_valid || dn_ready);
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (dn_valid && !dn_ready),
    .q   (stall_cnt)
  );

  a_up_sample : assert property (@(posedge clk) (load_main_up || load_skid) |-> up_xfer);
  a_occ_max   : assert property (@(posedge clk) disable iff (reset) occupancy <= 2'(SKID + 1));
  a_hold      : assert property (@(posedge clk) disable iff (reset)
                  (dn_valid && !dn_ready && !flush && !reset) |=> (dn_valid && $stable(dn_data)));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a SKID=0 and a SKID=1 stage with identical stimulus and checks both against a 2-deep FIFO model.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic                up_valid = 1'b0;
  logic [DW-1:0]       up_data = '0;
  logic                dn_ready = 1'b1;
  logic [1:0]          up_ready_o;
  logic [1:0]          dn_valid_o;
  logic [1:0][DW-1:0]  dn_data_o;
  logic [1:0][1:0]     occ_o;
  logic [1:0][CW-1:0]  cnt_o;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference model: per instance a FIFO of held beats plus the stall counter.
  logic [DW-1:0] mbuf [2][2];
  int            msz  [2];
  int            mcnt [2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_s0 (
    .clk(clk), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready_o[0]), .up_data(up_data),
    .dn_valid(dn_valid_o[0]), .dn_ready(dn_ready), .dn_data(dn_data_o[0]),
    .occupancy(occ_o[0]), .stall_cnt(cnt_o[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready_o[1]), .up_data(up_data),
    .dn_valid(dn_valid_o[1]), .dn_ready(dn_ready), .dn_data(dn_data_o[1]),
    .occupancy(occ_o[1]), .stall_cnt(cnt_o[1])
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_rdy(input int i, input bit dr);
    return (i == 1) ? (msz[i] < 2) : (msz[i] == 0 || dr);
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("skid%0d.up_ready", i), DW'(up_ready_o[i]), DW'(m_rdy(i, dn_ready)));
      chk($sformatf("skid%0d.dn_valid", i), DW'(dn_valid_o[i]), DW'(msz[i] > 0));
      chk($sformatf("skid%0d.dn_data", i), dn_data_o[i], (msz[i] > 0) ? mbuf[i][0] : '0);
      chk($sformatf("skid%0d.occupancy", i), DW'(occ_o[i]), DW'(msz[i]));
      chk($sformatf("skid%0d.stall_cnt", i), DW'(cnt_o[i]), DW'(mcnt[i]));
    end
  endtask

  // One clock cycle: apply inputs after negedge, check, then advance the model at posedge.
  task automatic step(input bit r, input bit f, input bit uv, input logic [DW-1:0] ud, input bit dr);
    bit rdy [2];
    bit dv;
    reset = r; flush = f; up_valid = uv; up_data = ud; dn_ready = dr;
    #1;
    for (int i = 0; i < 2; i++) rdy[i] = m_rdy(i, dr);
    if (chk_on) check_outputs();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      dv = (msz[i] > 0);
      if (r) begin
        msz[i]  = 0;
        mcnt[i] = 0;
      end else begin
        if (dv && !dr && mcnt[i] < (2**CW - 1)) mcnt[i]++;
        if (f) begin
          msz[i] = 0;
        end else begin
          if (dv && dr) begin
            mbuf[i][0] = mbuf[i][1];
            msz[i]--;
          end
          if (uv && rdy[i]) begin
            mbuf[i][msz[i]] = ud;
            msz[i]++;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      msz[i] = 0; mcnt[i] = 0; mbuf[i][0] = '0; mbuf[i][1] = '0;
    end
    @(negedge clk);

    // Reset two cycles, then idle bubbles
    step(1, 0, 0, 16'h0, 1);
    chk_on = 1'b1;
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Streaming
    step(0, 0, 1, 16'h0011, 1);
    step(0, 0, 1, 16'h0022, 1);
    step(0, 0, 1, 16'h0033, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Skid on stall, then release while C is still offered
    step(0, 0, 1, 16'h000A, 0);
    step(0, 0, 1, 16'h000B, 0);
    step(0, 0, 1, 16'h000C, 0);
    step(0, 0, 1, 16'h000C, 0);
    step(0, 0, 1, 16'h000C, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Flush while full with an offered beat
    step(0, 0, 1, 16'h00E0, 0);
    step(0, 0, 1, 16'h00F0, 0);
    step(0, 1, 1, 16'h000D, 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Single-entry mode: combinational ready and bubble-free pass-through
    step(0, 0, 1, 16'h0055, 0);
    dn_ready = 1'b0; up_valid = 1'b1;
    #1;
    chk("skid0.comb_rdy_lo", DW'(up_ready_o[0]), DW'(m_rdy(0, 1'b0)));
    chk("skid1.rdy_hold_lo", DW'(up_ready_o[1]), DW'(m_rdy(1, 1'b0)));
    dn_ready = 1'b1;
    #1;
    chk("skid0.comb_rdy_hi", DW'(up_ready_o[0]), DW'(m_rdy(0, 1'b1)));
    chk("skid1.rdy_hold_hi", DW'(up_ready_o[1]), DW'(m_rdy(1, 1'b1)));
    step(0, 0, 1, 16'h0066, 1);
    step(0, 0, 1, 16'h0077, 1);
    step(0, 0, 1, 16'h0088, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Counter saturation, then reset clears it
    step(1, 0, 0, 16'h0, 1);
    step(0, 0, 1, 16'h0099, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);

    // Randomized traffic with occasional flush, reset and long stalls
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 64) == 0,
           ($urandom % 16) == 0,
           ($urandom % 4) != 0,
           DW'($urandom),
           (k % 50 < 10) ? 1'b0 : (($urandom % 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
